// File: rtl/conv_seq_pkg.sv
// Shared types and constants for the 5x5 convolution frame sequencer.
package conv_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_CONV,
    ST_WRITE,
    ST_DONE
  } state_e;

  localparam int WIN_K = 5;
  localparam int WIN_N = 25;
  localparam int WIN_W = 200;

  localparam int RES_SINGLE_LSB = 0;
  localparam int RES_DUAL_LSB   = 16;

  function automatic logic [7:0] res_lsb(input logic [1:0] mode);
    logic [7:0] lsb;
    case (mode)
      2'b10, 2'b11: lsb = 8'(RES_DUAL_LSB);
      default:      lsb = 8'(RES_SINGLE_LSB);
    endcase
    return lsb;
  endfunction

endpackage

// File: rtl/window_addr_gen.sv
// Maps output pixel (x, y) and window element k to a source address,
// flagging elements that fall outside the image as zero padding.
module window_addr_gen
  import conv_seq_pkg::*;
#(
  parameter int IMG_W  = 160,
  parameter int IMG_H  = 120,
  parameter int ADDR_W = 15
) (
  input  logic [$clog2(IMG_W)-1:0] x,
  input  logic [$clog2(IMG_H)-1:0] y,
  input  logic [4:0]               k,
  output logic [ADDR_W-1:0]        rd_addr,
  output logic                     pad
);

  localparam int XW  = $clog2(IMG_W);
  localparam int YW  = $clog2(IMG_H);
  localparam int SXW = XW + 2;
  localparam int SYW = YW + 2;

  logic [2:0]     r;
  logic [2:0]     c;
  logic [SXW-1:0] ux;
  logic [SYW-1:0] uy;

  // ux/uy carry the +2 offset so the left/top border needs no sign bit
  always_comb begin
    r  = 3'(k / 5'(WIN_K));
    c  = 3'(k % 5'(WIN_K));
    ux = SXW'(x) + SXW'(c);
    uy = SYW'(y) + SYW'(r);
    pad = (ux < SXW'(2)) || (ux >= SXW'(IMG_W + 2)) ||
          (uy < SYW'(2)) || (uy >= SYW'(IMG_H + 2));
    rd_addr = ADDR_W'(uy - SYW'(2)) * ADDR_W'(IMG_W) +
              ADDR_W'(ux - SXW'(2));
  end

endmodule

// File: rtl/conv_frame_sequencer.sv
// Frame controller for the 5x5 convolution unit: fetch window, convolve, write.
// Optional ROI bypass is enabled by defining CONV_SEQ_ROI_EN.
module conv_frame_sequencer
  import conv_seq_pkg::*;
#(
  parameter int IMG_W  = 160,
  parameter int IMG_H  = 120,
  parameter int ADDR_W = 15
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     go,
  input  logic [1:0]               seletor,
`ifdef CONV_SEQ_ROI_EN
  input  logic [$clog2(IMG_W)-1:0] roi_x0,
  input  logic [$clog2(IMG_W)-1:0] roi_x1,
  input  logic [$clog2(IMG_H)-1:0] roi_y0,
  input  logic [$clog2(IMG_H)-1:0] roi_y1,
`endif
  output logic                     busy,
  output logic                     done_frame,
  output logic [ADDR_W-1:0]        rd_addr,
  input  logic [7:0]               rd_data,
  output logic                     wr_en,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [7:0]               wr_data,
  output logic [WIN_W-1:0]         conv_window,
  output logic                     conv_start,
  input  logic                     conv_done,
  input  logic [WIN_W-1:0]         conv_result
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);

  state_e           state_q, state_d;
  logic [XW-1:0]    x_q, x_d;
  logic [YW-1:0]    y_q, y_d;
  logic [4:0]       k_q, k_d;
  logic [1:0]       mode_q, mode_d;
  logic             cap_vld_q, cap_vld_d;
  logic             cap_pad_q, cap_pad_d;
  logic [4:0]       cap_k_q, cap_k_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [7:0]       res_q, res_d;

  logic              skip;
  logic              issue;
  logic [4:0]        k_rd;
  logic [ADDR_W-1:0] gen_addr;
  logic              gen_pad;
  logic [ADDR_W-1:0] pix_addr;

`ifdef CONV_SEQ_ROI_EN
  logic [XW-1:0] rx0_q, rx0_d, rx1_q, rx1_d;
  logic [YW-1:0] ry0_q, ry0_d, ry1_q, ry1_d;

  always_comb begin
    rx0_d = rx0_q;
    rx1_d = rx1_q;
    ry0_d = ry0_q;
    ry1_d = ry1_q;
    if (state_q == ST_IDLE && go) begin
      rx0_d = roi_x0;
      rx1_d = roi_x1;
      ry0_d = roi_y0;
      ry1_d = roi_y1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx0_q <= '0;
      rx1_q <= '0;
      ry0_q <= '0;
      ry1_q <= '0;
    end else begin
      rx0_q <= rx0_d;
      rx1_q <= rx1_d;
      ry0_q <= ry0_d;
      ry1_q <= ry1_d;
    end
  end

  assign skip = (x_q < rx0_q) || (x_q > rx1_q) ||
                (y_q < ry0_q) || (y_q > ry1_q);
`else
  assign skip = 1'b0;
`endif

  // bypassed pixels only need the centre element
  assign k_rd = skip ? 5'd12 : k_q;

  window_addr_gen #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .ADDR_W(ADDR_W)
  ) u_addr (
    .x      (x_q),
    .y      (y_q),
    .k      (k_rd),
    .rd_addr(gen_addr),
    .pad    (gen_pad)
  );

  assign issue = (state_q == ST_FETCH) &&
                 (skip ? (k_q == 5'd0) : (k_q < 5'(WIN_N)));
  assign pix_addr = ADDR_W'(y_q) * ADDR_W'(IMG_W) + ADDR_W'(x_q);

  assign rd_addr     = (issue && !gen_pad) ? gen_addr : '0;
  assign busy        = (state_q == ST_FETCH) || (state_q == ST_CONV) ||
                       (state_q == ST_WRITE);
  assign done_frame  = (state_q == ST_DONE);
  assign conv_start  = (state_q == ST_CONV);
  assign wr_en       = (state_q == ST_WRITE);
  assign wr_addr     = wr_en ? pix_addr : '0;
  assign wr_data     = wr_en ? res_q : '0;
  assign conv_window = win_q;

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    k_d       = k_q;
    mode_d    = mode_q;
    cap_vld_d = 1'b0;
    cap_pad_d = gen_pad;
    cap_k_d   = k_q;
    win_d     = win_q;
    res_d     = res_q;

    // read data lands one cycle after its address
    if (cap_vld_q) begin
      win_d[{cap_k_q, 3'b000} +: 8] = cap_pad_q ? 8'h00 : rd_data;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (go) begin
          mode_d  = seletor;
          x_d     = '0;
          y_d     = '0;
          k_d     = '0;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (skip) begin
          if (k_q == 5'd0) begin
            k_d = 5'd1;
          end else begin
            res_d   = rd_data;
            k_d     = '0;
            state_d = ST_WRITE;
          end
        end else begin
          cap_vld_d = (k_q < 5'(WIN_N));
          if (k_q == 5'(WIN_N)) begin
            k_d     = '0;
            state_d = ST_CONV;
          end else begin
            k_d = k_q + 5'd1;
          end
        end
      end
      ST_CONV: begin
        if (conv_done) begin
          res_d   = conv_result[res_lsb(mode_q) +: 8];
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        state_d = ST_FETCH;
        if (x_q == XW'(IMG_W - 1)) begin
          x_d = '0;
          if (y_q == YW'(IMG_H - 1)) begin
            state_d = ST_DONE;
          end else begin
            y_d = y_q + YW'(1);
          end
        end else begin
          x_d = x_q + XW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      x_q       <= '0;
      y_q       <= '0;
      k_q       <= '0;
      mode_q    <= '0;
      cap_vld_q <= 1'b0;
      cap_pad_q <= 1'b0;
      cap_k_q   <= '0;
      win_q     <= '0;
      res_q     <= '0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      k_q       <= k_d;
      mode_q    <= mode_d;
      cap_vld_q <= cap_vld_d;
      cap_pad_q <= cap_pad_d;
      cap_k_q   <= cap_k_d;
      win_q     <= win_d;
      res_q     <= res_d;
    end
  end

endmodule

// File: tb/tb_conv_frame_sequencer.sv
// Bench for conv_frame_sequencer on a 4x3 frame with a latency-L conv stub.
module tb_conv_frame_sequencer;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int AW = 4;
  localparam int N  = W * H;

  logic           clk = 1'b0;
  logic           reset;
  logic           go;
  logic [1:0]     seletor;
  logic           busy;
  logic           done_frame;
  logic [AW-1:0]  rd_addr;
  logic [7:0]     rd_data;
  logic           wr_en;
  logic [AW-1:0]  wr_addr;
  logic [7:0]     wr_data;
  logic [199:0]   conv_window;
  logic           conv_start;
  logic           conv_done;
  logic [199:0]   conv_result;
`ifdef CONV_SEQ_ROI_EN
  logic [1:0] roi_x0, roi_x1, roi_y0, roi_y1;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int L = 3;
  bit cst = 1'b0;
  bit force_done = 1'b0;
  int cnt = 0;
  logic [7:0] src [16];
  int got [N];
  int wr_cnt, ord_err, rises, done_cnt, done_cyc, go_cyc;
  logic cs_prev = 1'b0;
  int st_sum, st_w;

  conv_frame_sequencer #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .go         (go),
    .seletor    (seletor),
`ifdef CONV_SEQ_ROI_EN
    .roi_x0     (roi_x0),
    .roi_x1     (roi_x1),
    .roi_y0     (roi_y0),
    .roi_y1     (roi_y1),
`endif
    .busy       (busy),
    .done_frame (done_frame),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .conv_window(conv_window),
    .conv_start (conv_start),
    .conv_done  (conv_done),
    .conv_result(conv_result)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rd_data <= src[rd_addr];
  always @(posedge clk) begin
    if (reset || !conv_start) cnt <= 0;
    else cnt <= cnt + 1;
  end

  assign conv_done = (conv_start && cnt == L - 1) || force_done;

  // stub: [7:0] saturated sum, [23:16] position-weighted sum, filler elsewhere
  always_comb begin
    st_sum = 0;
    st_w = 0;
    for (int k = 0; k < 25; k++) begin
      st_sum += int'(conv_window[8*k +: 8]);
      st_w += int'(conv_window[8*k +: 8]) * (k + 1);
    end
    conv_result = {25{8'hC3}};
    if (cst) begin
      conv_result[7:0]   = 8'h11;
      conv_result[23:16] = 8'hAA;
    end else begin
      conv_result[7:0]   = (st_sum > 255) ? 8'hFF : 8'(st_sum);
      conv_result[23:16] = 8'(st_w);
    end
  end

  always @(negedge clk) begin
    if (wr_en) begin
      if (int'(wr_addr) != wr_cnt) ord_err++;
      if (int'(wr_addr) < N) got[wr_addr] = int'(wr_data);
      wr_cnt++;
    end
    if (conv_start && !cs_prev) rises++;
    cs_prev = conv_start;
    if (done_frame) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  function automatic int win_elem(int x, int y, int k);
    int sx, sy;
    sx = x - 2 + k % 5;
    sy = y - 2 + k / 5;
    if (sx < 0 || sx >= W || sy < 0 || sy >= H) return 0;
    return int'(src[sy*W + sx]);
  endfunction

  function automatic int model_px(int x, int y, logic [1:0] m, bit c);
    int s, w, e;
    s = 0;
    w = 0;
    for (int k = 0; k < 25; k++) begin
      e = win_elem(x, y, k);
      s += e;
      w += e * (k + 1);
    end
    if (c) return m[1] ? 32'hAA : 32'h11;
    return m[1] ? (w % 256) : ((s > 255) ? 255 : s);
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic clear_stats();
    wr_cnt = 0;
    ord_err = 0;
    rises = 0;
    done_cnt = 0;
    for (int i = 0; i < N; i++) got[i] = -1;
  endtask

  task automatic start_go(input logic [1:0] m);
    seletor = m;
    go = 1'b1;
    tick();
    go = 1'b0;
    go_cyc = cyc;
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while (done_cnt == 0 && n < 2000) begin
      tick();
      n++;
    end
    check({nm, " done seen"}, int'(done_cnt > 0), 1);
  endtask

  task automatic run_frame(input logic [1:0] m, input string nm,
                           input int exp_lat, input int exp_rises);
    clear_stats();
    start_go(m);
    wait_done(nm);
    check({nm, " latency"}, done_cyc - go_cyc + 1, exp_lat);
    check({nm, " writes"}, wr_cnt, N);
    check({nm, " order"}, ord_err, 0);
    check({nm, " starts"}, rises, exp_rises);
    tick();
    tick();
  endtask

  function automatic int frame_lat();
    return N * (27 + L) + 1;
  endfunction

  typedef struct {
    logic [1:0] mode;
    bit         cst;
    int         addr;
    int         exp;
  } vec_t;

  vec_t tbl [14];

  initial begin
    int n, w0;
    logic [1:0] m;

    // 4x3 frame: every window keeps 3 rows; 3 or 4 columns
    tbl[0]  = '{2'b00, 1'b0, 0, 9};
    tbl[1]  = '{2'b00, 1'b0, 1, 12};
    tbl[2]  = '{2'b00, 1'b0, 2, 12};
    tbl[3]  = '{2'b00, 1'b0, 3, 9};
    tbl[4]  = '{2'b00, 1'b0, 5, 12};
    tbl[5]  = '{2'b00, 1'b0, 8, 9};
    tbl[6]  = '{2'b00, 1'b0, 11, 9};
    tbl[7]  = '{2'b10, 1'b1, 0, 8'hAA};
    tbl[8]  = '{2'b10, 1'b1, 6, 8'hAA};
    tbl[9]  = '{2'b10, 1'b1, 11, 8'hAA};
    tbl[10] = '{2'b11, 1'b1, 4, 8'hAA};
    tbl[11] = '{2'b01, 1'b1, 7, 8'h11};
    tbl[12] = '{2'b10, 1'b0, 0, 171};
    tbl[13] = '{2'b00, 1'b0, 9, 12};

`ifdef CONV_SEQ_ROI_EN
    roi_x0 = 2'd0;
    roi_x1 = 2'd3;
    roi_y0 = 2'd0;
    roi_y1 = 2'd2;
`endif
    for (int i = 0; i < 16; i++) src[i] = (i < N) ? 8'd1 : 8'd0;
    seletor = 2'b00;
    reset = 1'b1;
    go = 1'b1;
    tick();
    tick();
    check("rst busy", int'(busy), 0);
    check("rst done", int'(done_frame), 0);
    check("rst wr_en", int'(wr_en), 0);
    check("rst conv_start", int'(conv_start), 0);
    check("rst rd_addr", int'(rd_addr), 0);
    check("rst wr_addr", int'(wr_addr), 0);
    check("rst wr_data", int'(wr_data), 0);
    check("rst window", int'(conv_window != '0), 0);
    reset = 1'b0;
    go = 1'b0;
    tick();
    check("go under reset", int'(busy), 0);

    for (int i = 0; i < 14; i++) begin
      if (i == 0 || tbl[i].mode != tbl[i-1].mode || tbl[i].cst != tbl[i-1].cst) begin
        cst = tbl[i].cst;
        run_frame(tbl[i].mode, $sformatf("tbl%0d", i), frame_lat(), N);
      end
      check($sformatf("tbl%0d px%0d", i, tbl[i].addr), got[tbl[i].addr], tbl[i].exp);
    end

    // window contents for pixel (0,0) on a ramp image
    for (int i = 0; i < N; i++) src[i] = 8'((i / W) * 10 + i % W);
    cst = 1'b0;
    clear_stats();
    start_go(2'b00);
    n = 0;
    while (!conv_start && n < 100) begin
      tick();
      n++;
    end
    check("first conv_start", int'(conv_start), 1);
    for (int k = 0; k < 25; k++)
      check($sformatf("win k%0d", k), int'(conv_window[8*k +: 8]), win_elem(0, 0, k));
    wait_done("ramp");
    check("ramp latency", done_cyc - go_cyc + 1, frame_lat());
    tick();

    // go while busy and stray conv_done during fetch are ignored
    cst = 1'b1;
    clear_stats();
    start_go(2'b00);
    repeat (4) tick();
    force_done = 1'b1;
    seletor = 2'b10;
    go = 1'b1;
    tick();
    go = 1'b0;
    repeat (2) tick();
    force_done = 1'b0;
    wait_done("busy go");
    check("busy go latency", done_cyc - go_cyc + 1, frame_lat());
    check("busy go writes", wr_cnt, N);
    for (int a = 0; a < N; a++)
      check($sformatf("busy go px%0d", a), got[a], 8'h11);
    repeat (5) tick();
    check("busy go one done", done_cnt, 1);

    // reset during pixel 5 convolution
    cst = 1'b0;
    clear_stats();
    start_go(2'b00);
    n = 0;
    while (rises < 6 && n < 400) begin
      tick();
      n++;
    end
    check("reach pixel 5", rises, 6);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort conv_start", int'(conv_start), 0);
    check("abort busy", int'(busy), 0);
    check("abort writes", wr_cnt, 5);
    w0 = wr_cnt;
    repeat (60) tick();
    check("no writes after abort", wr_cnt, w0);
    run_frame(2'b00, "restart", frame_lat(), N);
    check("restart px0", got[0], model_px(0, 0, 2'b00, 1'b0));

    // random images, modes and conv latencies
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < N; i++) src[i] = 8'($urandom);
      m = 2'($urandom);
      L = $urandom_range(1, 4);
      run_frame(m, $sformatf("rand%0d", t), frame_lat(), N);
      for (int a = 0; a < N; a++)
        check($sformatf("rand%0d px%0d", t, a), got[a], model_px(a % W, a / W, m, 1'b0));
    end
    L = 3;

`ifdef CONV_SEQ_ROI_EN
    roi_x0 = 2'd1;
    roi_x1 = 2'd2;
    roi_y0 = 2'd1;
    roi_y1 = 2'd1;
    for (int i = 0; i < N; i++) src[i] = 8'($urandom);
    run_frame(2'b00, "roi", 10 * 3 + 2 * 30 + 1, 2);
    for (int a = 0; a < N; a++)
      check($sformatf("roi px%0d", a), got[a],
            (a == 5 || a == 6) ? model_px(a % W, a / W, 2'b00, 1'b0) : int'(src[a]));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
